imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Byte-stream program loader; the write side of the instruction memory.
//   - Receives a framed byte stream over a valid/ready handshake.
//   - Assembles little-endian 32-bit words and drives the imem write port (WE/WA/WD).
//   - Holds the core in reset (cpu_hold) until a complete, valid image is written.
// PARAMETERS
//   n        32   address width of WA (byte address, word aligned)
//   width    32   instruction word width; fixed at 32 (4 bytes per word)
//   entries  265  imem depth in words; larger images are rejected
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   start       in   1      1-cycle pulse; begins a load from IDLE, DONE or ERR
//   byte_valid  in   1      byte_data is valid this cycle
//   byte_data   in   8      stream byte
//   byte_ready  out  1      loader accepts byte this cycle (xfer = valid & ready)
//   WE          out  1      imem write enable, 1-cycle pulse per word
//   WA          out  n      imem byte address = word_idx << 2
//   WD          out  width  assembled instruction word
//   cpu_hold    out  1      1 = keep core in reset
//   done        out  1      level; image loaded successfully
//   error       out  1      level; image rejected
// BEHAVIOUR
//   - Reset values: byte_ready=0, WE=0, WA=0, WD=0, cpu_hold=1, done=0, error=0.
//     FSM returns to IDLE; word_idx, byte_cnt and len are cleared.
//   - Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes, LSB first.
//   - States and transitions:
//     - IDLE: ready=0. start -> HDR0.
//     - HDR0: ready=1. xfer -> len[7:0], then HDR1.
//     - HDR1: ready=1. xfer -> len[15:8], then the exit below, chosen on the assembled len:
//       - len==0 -> DONE.
//       - len>entries -> ERR.
//       - otherwise -> DATA.
//     - DATA: ready=1. Each xfer shifts the byte into WD[8*byte_cnt+:8].
//       On the 4th byte (byte_cnt==3) -> WRITE.
//     - WRITE: ready=0. WE=1 for exactly one cycle with WA=word_idx<<2 and WD stable.
//       Then word_idx++, byte_cnt=0.
//       - word_idx==len-1 -> DONE (or CSUM with the macro below).
//       - otherwise -> DATA.
//     - DONE: ready=0, done=1, cpu_hold=0. start -> HDR0 and clears done.
//     - ERR: ready=0, error=1, cpu_hold=1. start -> HDR0 and clears error.
//   - cpu_hold=1 in every state except DONE; it is asserted again on the cycle start is taken in DONE.
//   - start in HDR0/HDR1/DATA/WRITE is ignored.
//   - Bytes offered while ready=0 are not consumed; the source must hold them.
//   - Latency: WE asserts the cycle after the 4th byte of a word is accepted.
//     Peak rate is 4 bytes per 5 cycles.
//   - Last word: with len==entries, last WA=(entries-1)<<2. word_idx never wraps.
//   - Width rules: WA is zero-extended to n bits; len compares as unsigned 16-bit.
//   - Reset mid-load: WE drops immediately (async), the partial word is discarded,
//     and previously written words are left as-is.
// CONFIGURATION
//   IMEM_LOADER_CHECKSUM_EN
//   - Defined:
//     - After the last WRITE -> CSUM state (ready=1).
//     - One trailing byte = XOR of all 4*N data bytes.
//     - Match -> DONE; mismatch -> ERR.
//     - len==0 expects checksum 8'h00.
//   - Undefined: no CSUM state, no trailing byte; the last WRITE goes straight to DONE.
// TESTING
//   1. rst=1 mid-DATA after 2 bytes -> same cycle WE=0, cpu_hold=1; after release, IDLE and ready=0.
//   2. start; stream 01 00 13 05 10 00 -> one WE pulse, WA=0, WD=32'h00100513;
//      next cycle done=1, cpu_hold=0.
//   3. start; len=3, byte_valid toggling every other cycle -> 3 WE pulses at WA=0,4,8; done=1.
//   4. start; len=266 (0A 01) -> ERR, error=1, no WE, cpu_hold=1;
//      then start with len=265 -> last WA=0x420, done=1.
//   5. start; len=0 (00 00) -> DONE with zero WE pulses;
//      start pulsed in DATA -> ignored, no state change.
//   6. (CHECKSUM_EN) len=1, data 13 05 10 00, csum 8'h06 -> done;
//      csum 8'h07 -> error=1, WE already issued once.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: frames LEN_LO, LEN_HI, 4*N data bytes into imem words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader #(
   parameter int n       = 32,
   parameter int width   = 32,
   parameter int entries = 265
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             WE,
   output logic [n-1:0]     WA,
   output logic [width-1:0] WD,
   output logic             cpu_hold,
   output logic             done,
   output logic             error
);

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WRITE,
      DONE,
      ERR,
      CSUM
   } state_t;

   state_t      state;
   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic        xfer;
   logic [15:0] len_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign xfer     = byte_valid & byte_ready;
   // Word count as it will be once the high header byte lands this cycle.
   assign len_full = {byte_data, len[7:0]};

   // All outputs are registered and change together with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         len        <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         byte_ready <= 1'b0;
         WE         <= 1'b0;
         WA         <= '0;
         WD         <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         WE <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state      <= HDR0;
                  byte_ready <= 1'b1;
                  cpu_hold   <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  len        <= '0;
                  word_idx   <= '0;
                  byte_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum       <= '0;
`endif
               end
            end
            HDR0: begin
               if (xfer) begin
                  len[7:0] <= byte_data;
                  state    <= HDR1;
               end
            end
            HDR1: begin
               if (xfer) begin
                  len[15:8] <= byte_data;
                  if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state      <= CSUM;
`else
                     state      <= DONE;
                     byte_ready <= 1'b0;
                     done       <= 1'b1;
                     cpu_hold   <= 1'b0;
`endif
                  end else if (len_full > 16'(entries)) begin
                     state      <= ERR;
                     byte_ready <= 1'b0;
                     error      <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  WD[8*byte_cnt +: 8] <= byte_data;
                  byte_cnt            <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum                <= csum ^ byte_data;
`endif
                  if (byte_cnt == 2'd3) begin
                     state      <= WRITE;
                     byte_ready <= 1'b0;
                     WE         <= 1'b1;
                     WA         <= n'(word_idx) << 2;
                  end
               end
            end
            WRITE: begin
               word_idx <= word_idx + 16'd1;
               byte_cnt <= '0;
               if (word_idx == len - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state      <= CSUM;
                  byte_ready <= 1'b1;
`else
                  state      <= DONE;
                  done       <= 1'b1;
                  cpu_hold   <= 1'b0;
`endif
               end else begin
                  state      <= DATA;
                  byte_ready <= 1'b1;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
               if (xfer) begin
                  byte_ready <= 1'b0;
                  if (byte_data == csum) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state      <= IDLE;
               byte_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random images checked against a byte-list model.
// Follows IMEM_LOADER_CHECKSUM_EN the same way the design does.
`timescale 1ns/1ps
module tb_imem_loader;

   localparam int ENTRIES = 265;

   logic        clk        = 1'b0;
   logic        rst        = 1'b0;
   logic        start      = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data  = 8'h00;
   logic        byte_ready;
   logic        WE;
   logic [31:0] WA;
   logic [31:0] WD;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;

   logic [31:0] gotWa[$];
   logic [31:0] gotWd[$];

   imem_loader #(.n(32), .width(32), .entries(ENTRIES)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .WE(WE), .WA(WA),
      .WD(WD), .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Every cycle with WE high is one imem write; log it for the model to check.
   always @(negedge clk) begin
      if (WE === 1'b1) begin
         gotWa.push_back(WA);
         gotWd.push_back(WD);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offers one byte after gap idle cycles and holds it until accepted.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int waitCnt;
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      waitCnt    = 0;
      while (byte_ready !== 1'b1 && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      if (waitCnt >= 50) checkOutput("ready_timeout", 32'(byte_ready), 32'd1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Loads one image of lenv words; the model is the plain list of bytes sent.
   task automatic runFrame(input logic [15:0] lenv, input int gap, input bit midStart, input bit badCsum);
      logic [7:0]  data[$];
      logic [7:0]  x;
      logic [31:0] expWd;
      bit          accepted;
      bit          expOk;
      int          nw;
      int          w;
      gotWa.delete();
      gotWd.delete();
      pulseStart();
      checkOutput("start_hold", 32'(cpu_hold), 32'd1);
      checkOutput("start_done_clr", 32'(done), 32'd0);
      checkOutput("start_err_clr", 32'(error), 32'd0);
      checkOutput("start_ready", 32'(byte_ready), 32'd1);
      applyStimulus(lenv[7:0], gap);
      applyStimulus(lenv[15:8], gap);
      accepted = (int'(lenv) <= ENTRIES);
      nw       = accepted ? int'(lenv) : 0;
      expOk    = accepted;
      x        = 8'h00;
      for (int i = 0; i < 4 * nw; i++) begin
         data.push_back(8'($urandom_range(0, 255)));
         x = x ^ data[i];
         applyStimulus(data[i], gap);
         if (midStart && i == 0) pulseStart();
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accepted) begin
         applyStimulus(badCsum ? (x ^ 8'h01) : x, gap);
         expOk = !badCsum;
      end
`else
      if (badCsum) expOk = accepted;
`endif
      w = 0;
      while (done !== 1'b1 && error !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      #1;
      checkOutput("end_done", 32'(done), 32'(expOk));
      checkOutput("end_error", 32'(error), 32'(!expOk));
      checkOutput("end_hold", 32'(cpu_hold), 32'(!expOk));
      checkOutput("end_ready", 32'(byte_ready), 32'd0);
      checkOutput("we_count", 32'(gotWa.size()), 32'(nw));
      for (int i = 0; i < nw && i < gotWa.size(); i++) begin
         expWd = {data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]};
         checkOutput($sformatf("wa[%0d]", i), gotWa[i], 32'(i * 4));
         checkOutput($sformatf("wd[%0d]", i), gotWd[i], expWd);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", 32'(byte_ready), 32'd0);
      checkOutput("rst_we", 32'(WE), 32'd0);
      checkOutput("rst_wa", WA, 32'd0);
      checkOutput("rst_wd", WD, 32'd0);
      checkOutput("rst_hold", 32'(cpu_hold), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_error", 32'(error), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("idle_ready", 32'(byte_ready), 32'd0);

      // Directed single-word image with latency checks around the write.
      pulseStart();
      applyStimulus(8'h01, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h13, 0);
      applyStimulus(8'h05, 0);
      applyStimulus(8'h10, 0);
      applyStimulus(8'h00, 0);
      checkOutput("t2_we", 32'(WE), 32'd1);
      checkOutput("t2_wa", WA, 32'd0);
      checkOutput("t2_wd", WD, 32'h00100513);
`ifdef IMEM_LOADER_CHECKSUM_EN
      applyStimulus(8'h06, 0);
`else
      @(negedge clk);
`endif
      checkOutput("t2_we_pulse", 32'(WE), 32'd0);
      checkOutput("t2_done", 32'(done), 32'd1);
      checkOutput("t2_hold", 32'(cpu_hold), 32'd0);

      // Reset in the middle of a word.
      pulseStart();
      applyStimulus(8'h03, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'hAA, 0);
      applyStimulus(8'hBB, 0);
      rst = 1'b1;
      #1;
      checkOutput("t1_we", 32'(WE), 32'd0);
      checkOutput("t1_hold", 32'(cpu_hold), 32'd1);
      checkOutput("t1_ready_async", 32'(byte_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("t1_idle_ready", 32'(byte_ready), 32'd0);
      checkOutput("t1_idle_done", 32'(done), 32'd0);

      // Reset while a write pulse is on the port.
      pulseStart();
      applyStimulus(8'h02, 0);
      applyStimulus(8'h00, 0);
      for (int i = 0; i < 4; i++) applyStimulus(8'(i + 1), 0);
      checkOutput("rw_we_high", 32'(WE), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("rw_we_drop", 32'(WE), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      runFrame(16'd3, 1, 1'b0, 1'b0);
      runFrame(16'd266, 0, 1'b0, 1'b0);
      runFrame(16'd265, 0, 1'b0, 1'b0);
      runFrame(16'd0, 0, 1'b0, 1'b0);
      runFrame(16'd2, 0, 1'b1, 1'b0);
      runFrame(16'hFFFF, 0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++)
         runFrame(16'($urandom_range(1, 8)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      runFrame(16'd1, 0, 1'b0, 1'b1);
      runFrame(16'd0, 0, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
